rv32imac_fetch_align: RTL and testbench

Instruction realignment stage between the I$ fetch port and the compressed decoder (c_decode). It accepts word-aligned 32-bit fetch words and emits one instruction per handshake. Each instruction goes out as instr_raw, with its PC and error flag.
- A 16-bit instruction is right-justified in instr_raw.
- A 32-bit instruction may straddle two fetch words. A one-halfword hold buffer joins the two halves.
- Halfword-aligned redirect targets are also handled.

---
 rtl/rv32imac_fetch_align_if.sv | 24 ++
 rtl/rv32imac_fetch_align.sv | 131 +++++++++++++
 tb/tb_rv32imac_fetch_align.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rv32imac_fetch_align_if.sv
// rtl/rv32imac_fetch_align_if.sv - fetch-word and instruction handshake bundle for the realignment stage
interface rv32imac_fetch_align_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i;
    logic        fetch_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_raw_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;

    modport master (
        output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, fetch_err_i, instr_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_raw_o, instr_pc_o, instr_err_o
    );

    modport slave (
        input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, fetch_err_i, instr_ready_i,
        output fetch_ready_o, instr_valid_o, instr_raw_o, instr_pc_o, instr_err_o
    );
endinterface

// File: rtl/rv32imac_fetch_align.sv
// rtl/rv32imac_fetch_align.sv - realigns word fetches into 16/32-bit instructions using a one-halfword hold buffer
module rv32imac_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rv32imac_fetch_align_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_ALIGNED = 2'd0,
        ST_SKIP    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h1;
    localparam state_t      RESET_ST   = RESET_PC[1] ? ST_SKIP : ST_ALIGNED;

    state_t      r_st;
    logic [31:0] r_pc;
    logic [15:0] r_hold;
    logic        r_hold_err;

    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic        w_lo_32b;
    logic        w_hold_32b;
    logic        w_instr_valid;
    logic        w_fetch_ready;
    logic [31:0] w_raw;
    logic        w_err;
    logic        w_instr_hs;
    logic        w_fetch_hs;

    assign w_lo       = bus.fetch_data_i[15:0];
    assign w_hi       = bus.fetch_data_i[31:16];
    assign w_lo_32b   = (w_lo[1:0] == 2'b11);
    assign w_hold_32b = (r_hold[1:0] == 2'b11);

    always_comb begin
        w_instr_valid = 1'b0;
        w_fetch_ready = 1'b0;
        w_raw         = 32'h0;
        w_err         = 1'b0;
        if (!bus.flush_i) begin
            case (r_st)
                ST_ALIGNED: begin
                    w_instr_valid = bus.fetch_valid_i;
                    w_fetch_ready = bus.instr_ready_i;
                    w_raw         = w_lo_32b ? bus.fetch_data_i : {16'h0, w_lo};
                    w_err         = bus.fetch_err_i;
                end
                ST_SKIP: begin
                    w_fetch_ready = 1'b1;
                end
                ST_HOLD: begin
                    // A buffered 32-bit head needs the next word's low half before it can issue.
                    if (w_hold_32b) begin
                        w_instr_valid = bus.fetch_valid_i;
                        w_fetch_ready = bus.instr_ready_i;
                        w_raw         = {w_lo, r_hold};
                        w_err         = r_hold_err | bus.fetch_err_i;
                    end else begin
                        w_instr_valid = 1'b1;
                        w_raw         = {16'h0, r_hold};
                        w_err         = r_hold_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_instr_hs = w_instr_valid & bus.instr_ready_i;
    assign w_fetch_hs = bus.fetch_valid_i & w_fetch_ready;

    assign bus.instr_valid_o = w_instr_valid;
    assign bus.fetch_ready_o = w_fetch_ready;
    assign bus.instr_raw_o   = w_raw;
    assign bus.instr_err_o   = w_err;
    assign bus.instr_pc_o    = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= RESET_ST;
            r_pc       <= RESET_PC_A;
            r_hold     <= 16'h0;
            r_hold_err <= 1'b0;
        end else if (bus.flush_i) begin
            r_pc       <= bus.flush_pc_i & ~32'h1;
            r_hold_err <= 1'b0;
            r_st       <= bus.flush_pc_i[1] ? ST_SKIP : ST_ALIGNED;
        end else begin
            case (r_st)
                ST_ALIGNED: begin
                    if (w_instr_hs) begin
                        if (w_lo_32b) begin
                            r_pc <= r_pc + 32'd4;
                        end else begin
                            r_hold     <= w_hi;
                            r_hold_err <= bus.fetch_err_i;
                            r_pc       <= r_pc + 32'd2;
                            r_st       <= ST_HOLD;
                        end
                    end
                end
                ST_SKIP: begin
                    if (w_fetch_hs) begin
                        r_hold     <= w_hi;
                        r_hold_err <= bus.fetch_err_i;
                        r_st       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_instr_hs) begin
                        if (w_hold_32b) begin
                            r_hold     <= w_hi;
                            r_hold_err <= bus.fetch_err_i;
                            r_pc       <= r_pc + 32'd4;
                        end else begin
                            r_pc <= r_pc + 32'd2;
                            r_st <= ST_ALIGNED;
                        end
                    end
                end
                default: r_st <= ST_ALIGNED;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32imac_fetch_align.sv
// tb/tb_rv32imac_fetch_align.sv - table-driven bench for rv32imac_fetch_align
module tb_rv32imac_fetch_align;

    logic clk;
    logic rst_n;

    rv32imac_fetch_align_if bus ();
    rv32imac_fetch_align_if bus2 ();

    rv32imac_fetch_align #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rv32imac_fetch_align #(.RESET_PC(32'h0000_0087)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [31:0] fpc;
        logic        fv;
        logic [31:0] fd;
        logic        fe;
        logic        ir;
        logic        e_fr;
        logic        e_v;
        logic [31:0] e_raw;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic [31:0] fpc, input logic fv, input logic [31:0] fd,
                       input logic fe, input logic ir, input logic e_fr, input logic e_v,
                       input logic [31:0] e_raw, input logic [31:0] e_pc, input logic e_err);
        vec_t v;
        v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.fe = fe; v.ir = ir;
        v.e_fr = e_fr; v.e_v = e_v; v.e_raw = e_raw; v.e_pc = e_pc; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic [31:0] fpc, input logic fv, input logic [31:0] fd,
                         input logic fe, input logic ir);
        bus.flush_i       = fl;
        bus.flush_pc_i    = fpc;
        bus.fetch_valid_i = fv;
        bus.fetch_data_i  = fd;
        bus.fetch_err_i   = fe;
        bus.instr_ready_i = ir;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        bus2.flush_i       = 1'b0;
        bus2.flush_pc_i    = 32'h0;
        bus2.fetch_valid_i = 1'b0;
        bus2.fetch_data_i  = 32'h0;
        bus2.fetch_err_i   = 1'b0;
        bus2.instr_ready_i = 1'b1;

        //   fl  fpc           fv  fd            fe  ir   fr  v   raw           pc            err
        add(0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0000_0000, 0); // reset state
        add(0, 32'h0,         1, 32'h0000_0013, 0, 1,  1, 1, 32'h0000_0013, 32'h0000_0000, 0);
        add(0, 32'h0,         1, 32'h4505_4501, 0, 1,  1, 1, 32'h0000_4501, 32'h0000_0004, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  0, 1, 32'h0000_4505, 32'h0000_0006, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0000_0008, 0);
        add(0, 32'h0,         1, 32'h0000_0013, 0, 0,  0, 1, 32'h0000_0013, 32'h0000_0008, 0); // stalled
        add(0, 32'h0,         1, 32'h0513_4501, 0, 1,  1, 1, 32'h0000_4501, 32'h0000_0008, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0000_000A, 0); // straddle waits
        add(0, 32'h0,         1, 32'h4505_0000, 0, 1,  1, 1, 32'h0000_0513, 32'h0000_000A, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  0, 1, 32'h0000_4505, 32'h0000_000E, 0);
        add(1, 32'h0000_0103, 1, 32'hFFFF_FFFF, 0, 1,  0, 0, 32'h0,         32'h0000_0010, 0); // flush
        add(0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0000_0102, 0);
        add(0, 32'h0,         1, 32'h0001_ABCD, 0, 1,  1, 0, 32'h0,         32'h0000_0102, 0); // skip lo
        add(0, 32'h0,         0, 32'h0,         0, 1,  0, 1, 32'h0000_0001, 32'h0000_0102, 0);
        add(0, 32'h0,         1, 32'h0513_4501, 0, 1,  1, 1, 32'h0000_4501, 32'h0000_0104, 0);
        for (int k = 0; k < 3; k++)
            add(0, 32'h0,     1, 32'h4505_0000, 0, 0,  0, 1, 32'h0000_0513, 32'h0000_0106, 0);
        add(0, 32'h0,         1, 32'h4505_0000, 0, 1,  1, 1, 32'h0000_0513, 32'h0000_0106, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  0, 1, 32'h0000_4505, 32'h0000_010A, 0);
        add(0, 32'h0,         1, 32'h0513_4501, 0, 1,  1, 1, 32'h0000_4501, 32'h0000_010C, 0); // error cases
        add(0, 32'h0,         1, 32'h4505_0000, 1, 1,  1, 1, 32'h0000_0513, 32'h0000_010E, 1);
        add(0, 32'h0,         0, 32'h0,         0, 1,  0, 1, 32'h0000_4505, 32'h0000_0112, 1);
        add(0, 32'h0,         1, 32'h0000_0013, 1, 1,  1, 1, 32'h0000_0013, 32'h0000_0114, 1);
        add(1, 32'hFFFF_FFFC, 0, 32'h0,         0, 1,  0, 0, 32'h0,         32'h0000_0118, 0); // wrap
        add(0, 32'h0,         1, 32'h4505_4501, 0, 1,  1, 1, 32'h0000_4501, 32'hFFFF_FFFC, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  0, 1, 32'h0000_4505, 32'hFFFF_FFFE, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0000_0000, 0);
        add(0, 32'h0,         1, 32'h0513_4501, 0, 1,  1, 1, 32'h0000_4501, 32'h0000_0000, 0);
        add(1, 32'h0000_0200, 1, 32'h4505_0000, 1, 1,  0, 0, 32'h0,         32'h0000_0002, 0); // flush mid-straddle
        add(0, 32'h0,         1, 32'h0000_0013, 0, 1,  1, 1, 32'h0000_0013, 32'h0000_0200, 0);
        add(0, 32'h0,         1, 32'h0513_4501, 0, 1,  1, 1, 32'h0000_4501, 32'h0000_0204, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].fpc, vecs[i].fv, vecs[i].fd, vecs[i].fe, vecs[i].ir);
            #2;
            check($sformatf("v%0d fetch_ready", i), {31'h0, bus.fetch_ready_o}, {31'h0, vecs[i].e_fr});
            check($sformatf("v%0d instr_valid", i), {31'h0, bus.instr_valid_o}, {31'h0, vecs[i].e_v});
            check($sformatf("v%0d instr_pc", i), bus.instr_pc_o, vecs[i].e_pc);
            if (vecs[i].e_v) begin
                check($sformatf("v%0d instr_raw", i), bus.instr_raw_o, vecs[i].e_raw);
                check($sformatf("v%0d instr_err", i), {31'h0, bus.instr_err_o}, {31'h0, vecs[i].e_err});
            end
        end

        // Asynchronous reset while a straddled head (0x0513) sits in the buffer.
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 32'h4505_0000, 1'b1, 1'b0);
        #2;
        check("pre-reset hold pc", bus.instr_pc_o, 32'h0000_0206);
        rst_n = 1'b0;
        #1;
        check("reset pc", bus.instr_pc_o, 32'h0000_0000);
        check("reset valid", {31'h0, bus.instr_valid_o}, 32'h1);
        check("reset raw", bus.instr_raw_o, 32'h0000_0000);
        check("reset err", {31'h0, bus.instr_err_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        #2;
        check("post-reset raw", bus.instr_raw_o, 32'h0000_0013);
        check("post-reset pc", bus.instr_pc_o, 32'h0000_0000);
        check("post-reset err", {31'h0, bus.instr_err_o}, 32'h0);

        // Second instance resets to an odd halfword: starts in SKIP.
        check("skip-reset pc", bus2.instr_pc_o, 32'h0000_0086);
        check("skip-reset valid", {31'h0, bus2.instr_valid_o}, 32'h0);
        check("skip-reset ready", {31'h0, bus2.fetch_ready_o}, 32'h1);
        bus2.fetch_valid_i = 1'b1;
        bus2.fetch_data_i  = 32'h0001_ABCD;
        @(negedge clk);
        bus2.fetch_valid_i = 1'b0;
        #2;
        check("skip-reset raw", bus2.instr_raw_o, 32'h0000_0001);
        check("skip-reset out pc", bus2.instr_pc_o, 32'h0000_0086);
        check("skip-reset out valid", {31'h0, bus2.instr_valid_o}, 32'h1);
        @(negedge clk);
        #2;
        check("skip-reset next pc", bus2.instr_pc_o, 32'h0000_0088);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
